bcd_seq_converter: RTL and testbench

//  Parametrised, clocked binary-to-BCD converter (shift-and-add-3 / double-dabble).

---
 rtl/bcd_seq_converter.sv | 158 +++++++++++++++
 tb/tb_bcd_seq_converter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
//------------------------------------------------------------------------------
// Module      : bcd_seq_converter
// Description : Sequential binary-to-BCD converter (shift-and-add-3).
//               Converts one input bit per clock behind a start/busy/done
//               handshake. Produces DIGITS packed BCD digits. An overflow
//               flag marks values that do not fit in DIGITS digits.
//               Optional macro BCD_LZ_BLANK_EN adds the blank_o port, which
//               carries leading-zero blanking flags for each digit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_out_o,
  output logic                  overflow_o
`ifdef BCD_LZ_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_o
`endif
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int                BCD_W    = 4 * DIGITS;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    shift_q;
  logic [BCD_W-1:0]    scratch_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_acc_q;
  logic                busy_q;
  logic                done_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                ovf_q;

  logic [BCD_W-1:0]    adj_d;
  logic [BCD_W-1:0]    scratch_d;
  logic [WIDTH-1:0]    shift_d;
  logic                bit_out_d;

  // Add 3 to every scratch digit that is 5 or more, all digits in parallel
  always_comb begin
    adj_d = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift {scratch, operand} left by one; the bit leaving the top digit feeds overflow
  always_comb begin
    bit_out_d = adj_d[BCD_W-1];
    scratch_d = {adj_d[BCD_W-2:0], shift_q[WIDTH-1]};
    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
  end

`ifdef BCD_LZ_BLANK_EN
  logic [DIGITS-1:0]   blank_d;
  logic [DIGITS-1:0]   blank_q;
  logic                zero_above_d;

  // Digit i is blanked when it and every higher digit of the final result are zero;
  // the units digit is never blanked so a zero value still shows "0"
  always_comb begin
    blank_d      = '0;
    zero_above_d = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above_d = zero_above_d & (scratch_d[4*i +: 4] == 4'd0);
      blank_d[i]   = zero_above_d;
    end
  end

  assign blank_o = blank_q;
`endif

  // Control FSM and datapath registers; results are only updated on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q   <= ST_CONV;
            busy_q    <= 1'b1;
            shift_q   <= bin_in_i;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
          end else begin
            state_q   <= ST_IDLE;
          end
        end

        ST_CONV: begin
          shift_q   <= shift_d;
          scratch_q <= scratch_d;
          ovf_acc_q <= ovf_acc_q | bit_out_d;
          if (cnt_q == LAST_CNT) begin
            // Final shift: publish the result and pulse done next cycle
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= scratch_d;
            ovf_q   <= ovf_acc_q | bit_out_d;
`ifdef BCD_LZ_BLANK_EN
            blank_q <= blank_d;
`endif
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign bcd_out_o  = bcd_q;
  assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_seq_converter
// Description : Self-checking bench for bcd_seq_converter (8-bit/3-digit and
//               10-bit/3-digit instances) using a results scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_seq_converter;

  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
    logic [2:0]  blank;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8;
  logic [7:0]  bin8;
  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;

  logic        start10;
  logic [9:0]  bin10;
  logic        busy10, done10, ovf10;
  logic [11:0] bcd10;

`ifdef BCD_LZ_BLANK_EN
  logic [2:0]  blank8, blank10;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   dones8 = 0;
  exp_t q8[$];
  exp_t q10[$];
  exp_t e8, e10;

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start8),
    .bin_in_i   (bin8),
    .busy_o     (busy8),
    .done_o     (done8),
    .bcd_out_o  (bcd8),
    .overflow_o (ovf8)
`ifdef BCD_LZ_BLANK_EN
    ,
    .blank_o    (blank8)
`endif
  );

  bcd_seq_converter #(.WIDTH(10), .DIGITS(3)) u_dut10 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start10),
    .bin_in_i   (bin10),
    .busy_o     (busy10),
    .done_o     (done10),
    .bcd_out_o  (bcd10),
    .overflow_o (ovf10)
`ifdef BCD_LZ_BLANK_EN
    ,
    .blank_o    (blank10)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, truncated to three digits
  function automatic exp_t model(input int v);
    exp_t r;
    int d0, d1, d2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = (v / 100) % 10;
    r.bcd      = {4'(d2), 4'(d1), 4'(d0)};
    r.ovf      = (v >= 1000);
    r.blank[0] = 1'b0;
    r.blank[1] = (d2 == 0) && (d1 == 0);
    r.blank[2] = (d2 == 0);
    return r;
  endfunction

  // Scoreboard for the 8-bit instance
  always @(negedge clk) begin
    if (!rst && done8) begin
      dones8++;
      if (q8.size() == 0) begin
        check_val("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        check_val("bcd8", bcd8, e8.bcd);
        check_val("ovf8", ovf8, e8.ovf);
`ifdef BCD_LZ_BLANK_EN
        check_val("blank8", blank8, e8.blank);
`endif
      end
    end
  end

  // Scoreboard for the 10-bit instance
  always @(negedge clk) begin
    if (!rst && done10) begin
      if (q10.size() == 0) begin
        check_val("done10_unexpected", 32'd1, 32'd0);
      end else begin
        e10 = q10.pop_front();
        check_val("bcd10", bcd10, e10.bcd);
        check_val("ovf10", ovf10, e10.ovf);
`ifdef BCD_LZ_BLANK_EN
        check_val("blank10", blank10, e10.blank);
`endif
      end
    end
  end

  // Wait (bounded) for done8; cycles counts from the cycle after acceptance
  task automatic wait_done8(inout int cycles, output int busy_cycles);
    busy_cycles = 0;
    while (!done8 && cycles < 40) begin
      if (busy8) busy_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
    check_val("done8_seen", done8, 1'b1);
  endtask

  task automatic run8(input int v, output int cycles, output int busy_cycles);
    start8 = 1'b1;
    bin8   = v[7:0];
    q8.push_back(model(v));
    @(posedge clk); #1;
    start8 = 1'b0;
    bin8   = ~bin8;
    cycles = 1;
    wait_done8(cycles, busy_cycles);
  endtask

  task automatic run10(input int v);
    int cyc;
    start10 = 1'b1;
    bin10   = v[9:0];
    q10.push_back(model(v));
    @(posedge clk); #1;
    start10 = 1'b0;
    bin10   = ~bin10;
    cyc = 1;
    while (!done10 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("done10_seen", done10, 1'b1);
    check_val("lat10", cyc, 11);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c, b, d0;
    rst = 1'b1; start8 = 1'b0; bin8 = '0; start10 = 1'b0; bin10 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy8, 1'b0);
    check_val("rst_done", done8, 1'b0);
    check_val("rst_bcd",  bcd8,  12'h000);
    check_val("rst_ovf",  ovf8,  1'b0);
`ifdef BCD_LZ_BLANK_EN
    check_val("rst_blank", blank8, 3'b000);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Conversion and latency
    run8(255, c, b);
    check_val("lat_255", c, 9);
    check_val("busy_255", b, 8);
    @(posedge clk); #1;

    // Zero and blanking
    run8(0, c, b);
    run8(7, c, b);
    run8(42, c, b);
    @(posedge clk); #1;

    // Start while busy is ignored
    d0 = dones8;
    start8 = 1'b1; bin8 = 8'd99; q8.push_back(model(99));
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start8 = 1'b1; bin8 = 8'd200;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("single_done", dones8 - d0, 1);

    // Back-to-back with start held through DONE
    start8 = 1'b1; bin8 = 8'd128; q8.push_back(model(128));
    @(posedge clk); #1;
    bin8 = 8'd64; q8.push_back(model(64));
    c = 1;
    wait_done8(c, b);
    check_val("b2b_first", c, 9);
    @(posedge clk); #1;
    start8 = 1'b0;
    c = 1;
    wait_done8(c, b);
    check_val("b2b_spacing", c, 9);
    @(posedge clk); #1;

    // Reset in the middle of a conversion
    d0 = dones8;
    start8 = 1'b1; bin8 = 8'd200;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_busy", busy8, 1'b0);
    check_val("midrst_done", done8, 1'b0);
    check_val("midrst_bcd",  bcd8,  12'h000);
    check_val("midrst_ovf",  ovf8,  1'b0);
    repeat (15) @(posedge clk);
    #1;
    check_val("midrst_no_done", dones8 - d0, 0);
    run8(37, c, b);
    @(posedge clk); #1;

    // Overflow on the 10-bit instance
    run10(1023);
    @(posedge clk); #1;
    run10(999);
    @(posedge clk); #1;

    // Full sweep
    for (int v = 0; v < 256; v++) begin
      run8(v, c, b);
    end
    repeat (4) @(posedge clk);
    #1;
    check_val("q8_empty",  q8.size(),  0);
    check_val("q10_empty", q10.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
